// File: rtl/csa_acc.sv
// ============================================================================
// Module   : csa_acc
// Purpose  : Carry-save packet accumulator with a 3:2 compressor tree on the
//            feedback path and a single CPA in the RESOLVE state.
// Options  : CSA_ACC_CNT_EN adds a saturating 16-bit beat counter (out_count).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module csa_acc #(
    parameter int WIDTH = 32,
    parameter int LANES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
`ifdef CSA_ACC_CNT_EN
    output logic [15:0]            out_count,
`endif
    output logic                   busy
);

    localparam int NOPS = LANES + 2;

    // Operand count entering layer l: each full group of three becomes two.
    function automatic int layer_ops(input int l);
        int n;
        n = NOPS;
        for (int i = 0; i < l; i++) begin
            n = 2 * (n / 3) + (n % 3);
        end
        return n;
    endfunction

    function automatic int num_layers();
        int n;
        int k;
        n = NOPS;
        k = 0;
        for (int i = 0; i < 16; i++) begin
            if (n > 2) begin
                n = 2 * (n / 3) + (n % 3);
                k = k + 1;
            end
        end
        return k;
    endfunction

    localparam int NL = num_layers();

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACC     = 2'd1,
        ST_RESOLVE = 2'd2,
        ST_OUT     = 2'd3
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_sum;
    logic [WIDTH-1:0] r_carry;
    logic [WIDTH-1:0] r_out_data;
    logic             w_accept;
    logic [WIDTH-1:0] w_lvl [NL+1][NOPS];

    // Level 0 holds the lanes followed by the redundant feedback pair.
    generate
        for (genvar j = 0; j < NOPS; j++) begin : g_src
            if (j < LANES) begin : g_lane
                assign w_lvl[0][j] = in_data[j*WIDTH +: WIDTH];
            end else if (j == LANES) begin : g_sum
                assign w_lvl[0][j] = r_sum;
            end else begin : g_carry
                assign w_lvl[0][j] = r_carry;
            end
        end

        for (genvar l = 0; l < NL; l++) begin : g_layer
            localparam int N_IN  = layer_ops(l);
            localparam int N_GRP = N_IN / 3;
            localparam int N_OUT = layer_ops(l + 1);
            for (genvar j = 0; j < NOPS; j++) begin : g_out
                if (j < 2 * N_GRP) begin : g_fa
                    localparam int A = 3 * (j / 2);
                    if (j % 2 == 0) begin : g_s
                        assign w_lvl[l+1][j] = w_lvl[l][A] ^ w_lvl[l][A+1] ^ w_lvl[l][A+2];
                    end else begin : g_c
                        // Majority shifted left; the bit leaving WIDTH-1 is dropped.
                        logic [WIDTH-2:0] w_maj;
                        assign w_maj = (w_lvl[l][A][WIDTH-2:0]   & w_lvl[l][A+1][WIDTH-2:0])
                                     | (w_lvl[l][A][WIDTH-2:0]   & w_lvl[l][A+2][WIDTH-2:0])
                                     | (w_lvl[l][A+1][WIDTH-2:0] & w_lvl[l][A+2][WIDTH-2:0]);
                        assign w_lvl[l+1][j] = {w_maj, 1'b0};
                    end
                end else if (j < N_OUT) begin : g_pass
                    assign w_lvl[l+1][j] = w_lvl[l][j + N_GRP];
                end else begin : g_zero
                    assign w_lvl[l+1][j] = '0;
                end
            end
        end
    endgenerate

    assign in_ready  = (r_state == ST_IDLE) || (r_state == ST_ACC);
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (r_state == ST_OUT);
    assign busy      = (r_state != ST_IDLE);
    assign out_data  = r_out_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_sum      <= '0;
            r_carry    <= '0;
            r_out_data <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_ACC: begin
                    if (w_accept) begin
                        r_sum   <= w_lvl[NL][0];
                        r_carry <= w_lvl[NL][1];
                        r_state <= in_last ? ST_RESOLVE : ST_ACC;
                    end
                end
                ST_RESOLVE: begin
                    r_out_data <= r_sum + r_carry;
                    r_sum      <= '0;
                    r_carry    <= '0;
                    r_state    <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef CSA_ACC_CNT_EN
    logic [15:0] r_cnt;
    logic [15:0] r_out_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_out_count <= '0;
        end else if (r_state == ST_RESOLVE) begin
            r_out_count <= r_cnt;
            r_cnt       <= '0;
        end else if (w_accept && (r_cnt != 16'hFFFF)) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    assign out_count = r_out_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_csa_acc.sv
// ============================================================================
// Module   : tb_csa_acc
// Purpose  : Directed self-checking bench for csa_acc (WIDTH=32, LANES=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_csa_acc;

    localparam int WIDTH = 32;
    localparam int LANES = 4;

    logic                   clk;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*WIDTH-1:0] in_data;
    logic                   in_last;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       out_data;
    logic                   busy;
`ifdef CSA_ACC_CNT_EN
    logic [15:0]            out_count;
`endif

    int n_checks;
    int n_errors;

    csa_acc #(.WIDTH(WIDTH), .LANES(LANES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef CSA_ACC_CNT_EN
        .out_count (out_count),
`endif
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LANES*WIDTH-1:0] pack4(input logic [31:0] a, input logic [31:0] b,
                                                     input logic [31:0] c, input logic [31:0] d);
        return {d, c, b, a};
    endfunction

    // Offers one beat, confirms it is acceptable, and clocks it in.
    task automatic send_beat(input string tag, input logic [LANES*WIDTH-1:0] d, input logic last);
        in_data  = d;
        in_last  = last;
        in_valid = 1'b1;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Called right after the last beat's edge: RESOLVE now, OUT after one more edge.
    task automatic get_result(input string tag, input logic [31:0] exp);
        check({tag, "_resolve_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_resolve_ready"}, 32'(in_ready), 32'd0);
        tick();
        check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_out_data"}, out_data, exp);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
`ifdef CSA_ACC_CNT_EN
        check("rst_count", 32'(out_count), 32'd0);
`endif

        // Single beat 1+2+3+4.
        send_beat("t1", pack4(32'd1, 32'd2, 32'd3, 32'd4), 1'b1);
        check("t1_busy", 32'(busy), 32'd1);
        get_result("t1", 32'h0000000A);

        // Three beats of -1 x4 = -12.
        send_beat("t2b0", pack4(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF), 1'b0);
        send_beat("t2b1", pack4(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF), 1'b0);
        send_beat("t2b2", pack4(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF), 1'b1);
`ifdef CSA_ACC_CNT_EN
        tick();
        check("t2_count", 32'(out_count), 32'd3);
        check("t2_out_data", out_data, 32'hFFFFFFF4);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        send_beat("t2c", pack4(32'd7, 32'd0, 32'd0, 32'd0), 1'b1);
        tick();
        check("t2c_count", 32'(out_count), 32'd1);
        check("t2c_out_data", out_data, 32'd7);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
`else
        get_result("t2", 32'hFFFFFFF4);
`endif

        // Modulo wrap.
        send_beat("t3a", pack4(32'h80000000, 32'h80000000, 32'd0, 32'd0), 1'b1);
        get_result("t3a", 32'h00000000);
        send_beat("t3b", pack4(32'h7FFFFFFF, 32'd1, 32'd0, 32'd0), 1'b1);
        get_result("t3b", 32'h80000000);

        // Backpressure in OUT with a beat waiting at the input.
        send_beat("t4", pack4(32'd1, 32'd1, 32'd1, 32'd1), 1'b1);
        tick();
        in_data  = pack4(32'd9, 32'd0, 32'd0, 32'd0);
        in_last  = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("t4_hold_valid", 32'(out_valid), 32'd1);
            check("t4_hold_data", out_data, 32'd4);
            check("t4_hold_ready", 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t4_idle_valid", 32'(out_valid), 32'd0);
        check("t4_idle_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        get_result("t4_next", 32'd9);

        // Reset in the middle of a packet.
        send_beat("t5b0", pack4(32'd5, 32'd5, 32'd5, 32'd5), 1'b0);
        send_beat("t5b1", pack4(32'd5, 32'd5, 32'd5, 32'd5), 1'b0);
        rst = 1'b1;
        #2;
        check("t5_rst_valid", 32'(out_valid), 32'd0);
        check("t5_rst_data", out_data, 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("t5_rel_ready", 32'(in_ready), 32'd1);
        send_beat("t5", pack4(32'd5, 32'd0, 32'd0, 32'd0), 1'b1);
        get_result("t5", 32'd5);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
